inst_mem_loadable: RTL and testbench
====================================

Name: inst_mem_loadable

Overview:
- Successor to the fixed instruction ROM: parametrised instruction memory (depth 2**IW, width DW).
- Loaded at run time over a byte-wide valid/ready port instead of from a file at elaboration.
- Gives a registered, stallable fetch port to the program counter.
- Sits between the boot/test harness (loader side) and the fetch stage; fetches beyond the loaded program length return a NOP word.

Parameters:
IW, 10, address width; memory depth = 2**IW words
DW, 9, instruction word width
NOP_WORD, 0, DW-bit value returned for fetches at addresses >= loaded length and at reset

Ports:
Clk  in  1  system clock, rising-edge
Reset_n  in  1  asynchronous, active-low reset
LoadStart  in  1  single-cycle request to begin a program load
LoadLen  in  IW+1  number of words to load; sampled with LoadStart
LoadData  in  8  load byte
LoadValid  in  1  LoadData valid
LoadReady  out  1  block accepts a byte this cycle
LoadDone  out  1  one-cycle pulse when the final word has been written
LoadErr  out  1  sticky flag: last LoadStart had an illegal LoadLen
Running  out  1  program loaded; fetch port active
InstAddress  in  IW  fetch address from the PC
FetchEn  in  1  perform a fetch this cycle (low = stall)
InstOut  out  DW  fetched instruction
InstValid  out  1  InstOut updated by a fetch in the previous cycle

Behaviour:
- NB = ceil(DW/8) bytes per word, little-endian: first byte -> bits [7:0], and so on.
- Bits of the last byte above DW are discarded.
- Reset (async assert, sync release) sets: state IDLE, LoadReady=0, LoadDone=0, LoadErr=0, Running=0, InstOut=NOP_WORD, InstValid=0, internal Loaded count=0, write pointer=0, byte index=0.
- Memory array is not reset; contents are unreachable while Loaded=0.
- States: IDLE, LOAD, RUN.
- IDLE:
  - LoadStart with 1 <= LoadLen <= 2**IW -> LOAD; clear write pointer, byte index and LoadErr; latch LoadLen.
  - LoadStart with an illegal LoadLen -> set LoadErr=1 and remain in IDLE.
- LOAD:
  - LoadReady=1 combinationally while in LOAD.
  - A byte is accepted on a cycle with LoadValid && LoadReady.
  - Gaps in LoadValid are legal and only pause assembly.
  - On the NB-th byte of a word: write the assembled word at the write pointer in that same clock edge, increment the pointer, reset the byte index.
  - After writing word LoadLen-1: next cycle is RUN, LoadDone=1 for exactly that one cycle, Loaded=LoadLen, LoadReady=0.
  - LoadStart is ignored in LOAD.
- RUN:
  - Running=1.
  - FetchEn=1: InstOut <= (InstAddress < Loaded) ? mem[InstAddress] : NOP_WORD; InstValid <= 1. Latency is exactly 1 cycle.
  - FetchEn=0: InstOut holds its value; InstValid <= 0.
  - LoadStart in RUN (reload): same legality check as IDLE. Legal -> LOAD next cycle, Running=0, InstValid=0, Loaded=0. Illegal -> LoadErr=1, stay in RUN.
- LoadStart and FetchEn both high in RUN: LoadStart wins; no fetch; InstOut holds.
- FetchEn outside RUN: ignored; InstValid=0; InstOut holds.
- Reset mid-load: returns to IDLE with Loaded=0. Partially written words are never fetchable.
- No read/write collision is possible: writes occur only in LOAD, reads only in RUN.

Test Plan:
- Reset, then FetchEn=1 with InstAddress=0 for 5 cycles in IDLE -> InstValid=0, InstOut=0x000, Running=0, LoadReady=0.
- DW=9: LoadStart, LoadLen=3; bytes E0,00,B0,00,91,00 back-to-back -> LoadDone pulses 1 cycle after the 6th byte, Running=1. Fetching addresses 0,1,2 on consecutive cycles -> InstOut=0x0E0,0x0B0,0x091, each one cycle later with InstValid=1.
- After that load: fetch address 3 -> 0x000 (NOP_WORD), InstValid=1. Then reload LoadLen=1 with bytes 12,FF -> fetch address 0 gives 0x112 (upper 7 bits of FF discarded); address 1 gives 0x000.
- Same 3-word load with LoadValid low for 2 cycles between every byte -> identical contents and fetch results; LoadReady stays 1 throughout LOAD.
- LoadLen=0, then LoadLen=1025 (IW=10) -> LoadErr=1, state unchanged, LoadReady=0. A following legal LoadStart clears LoadErr.
- Reset_n pulsed low after 3 bytes of a 2-word load -> IDLE. Then load 1 word (bytes 05,01) -> fetch address 0 gives 0x105, address 1 gives 0x000. In RUN, assert LoadStart and FetchEn together -> no fetch, InstValid=0, Running=0 next cycle.

Source files
------------

// File: rtl/inst_mem_loadable_if.sv
// Byte-wide program load port for inst_mem_loadable.
// Loader drives start/length/data; memory answers ready/done/err.
interface inst_mem_loadable_if #(
   parameter int IW = 10
);
   logic          LoadStart;
   logic [IW:0]   LoadLen;
   logic [7:0]    LoadData;
   logic          LoadValid;
   logic          LoadReady;
   logic          LoadDone;
   logic          LoadErr;

   modport master (
      output LoadStart, LoadLen, LoadData, LoadValid,
      input  LoadReady, LoadDone, LoadErr
   );

   modport slave (
      input  LoadStart, LoadLen, LoadData, LoadValid,
      output LoadReady, LoadDone, LoadErr
   );
endinterface

// File: rtl/inst_mem_loadable.sv
// Run-time loadable instruction memory with a registered, stallable
// fetch port; fetches past the loaded length return NOP_WORD.
module inst_mem_loadable #(
   parameter int            IW       = 10,
   parameter int            DW       = 9,
   parameter logic [DW-1:0] NOP_WORD = '0
) (
   input  logic                Clk,
   input  logic                Reset_n,
   inst_mem_loadable_if.slave  ld,
   output logic                Running,
   input  logic [IW-1:0]       InstAddress,
   input  logic                FetchEn,
   output logic [DW-1:0]       InstOut,
   output logic                InstValid
);

   localparam int NB = (DW + 7) / 8;
   localparam int BW = NB * 8;
   localparam int XW = (NB > 1) ? $clog2(NB) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LOAD = 2'd1;
   localparam logic [1:0] S_RUN  = 2'd2;

   logic [1:0]    state;
   logic [IW-1:0] wr_ptr;
   logic [XW-1:0] byte_idx;
   logic [BW-1:0] asm_q;
   logic [BW-1:0] asm_d;
   logic [IW:0]   load_len;
   logic [IW:0]   loaded;
   logic          load_done;
   logic          load_err;
   logic [DW-1:0] inst_out;
   logic          inst_valid;

   logic [DW-1:0] mem [2**IW];

   logic len_ok;
   logic start_ok;
   logic start_bad;
   logic accept;
   logic last_byte;
   logic last_word;

   // Legal length is 1..2**IW: top bit clear, or exactly 2**IW.
   assign len_ok    = (ld.LoadLen != '0) &&
                      (!ld.LoadLen[IW] || (ld.LoadLen[IW-1:0] == '0));
   assign start_ok  = ld.LoadStart && (state != S_LOAD) && len_ok;
   assign start_bad = ld.LoadStart && (state != S_LOAD) && !len_ok;
   assign accept    = (state == S_LOAD) && ld.LoadValid;
   assign last_byte = (byte_idx == XW'(NB - 1));
   assign last_word = ({1'b0, wr_ptr} == (load_len - 1'b1));

   always_comb begin
      asm_d = asm_q;
      asm_d[byte_idx*8 +: 8] = ld.LoadData;
   end

   // The word is committed on the edge that accepts its final byte.
   always_ff @(posedge Clk) begin
      if (accept && last_byte) begin
         mem[wr_ptr] <= asm_d[DW-1:0];
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state      <= S_IDLE;
         wr_ptr     <= '0;
         byte_idx   <= '0;
         asm_q      <= '0;
         load_len   <= '0;
         loaded     <= '0;
         load_done  <= 1'b0;
         load_err   <= 1'b0;
         inst_out   <= NOP_WORD;
         inst_valid <= 1'b0;
      end else begin
         load_done  <= 1'b0;
         inst_valid <= 1'b0;
         unique case (state)
            S_IDLE, S_RUN: begin
               if (start_ok) begin
                  state    <= S_LOAD;
                  wr_ptr   <= '0;
                  byte_idx <= '0;
                  load_err <= 1'b0;
                  load_len <= ld.LoadLen;
                  loaded   <= '0;
               end else if (start_bad) begin
                  load_err <= 1'b1;
               end else if ((state == S_RUN) && FetchEn) begin
                  inst_valid <= 1'b1;
                  inst_out   <= ({1'b0, InstAddress} < loaded) ?
                                mem[InstAddress] : NOP_WORD;
               end
            end
            S_LOAD: begin
               if (accept) begin
                  asm_q <= asm_d;
                  if (last_byte) begin
                     byte_idx <= '0;
                     wr_ptr   <= wr_ptr + 1'b1;
                     if (last_word) begin
                        state     <= S_RUN;
                        loaded    <= load_len;
                        load_done <= 1'b1;
                     end
                  end else begin
                     byte_idx <= byte_idx + 1'b1;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign ld.LoadReady = (state == S_LOAD);
   assign ld.LoadDone  = load_done;
   assign ld.LoadErr   = load_err;
   assign Running      = (state == S_RUN);
   assign InstOut      = inst_out;
   assign InstValid    = inst_valid;

endmodule

// File: tb/tb_inst_mem_loadable.sv
// Randomised and directed bench for inst_mem_loadable against
// an array model of the loaded program.
module tb_inst_mem_loadable;

   localparam int IW = 10;
   localparam int DW = 9;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   inst_mem_loadable_if #(.IW(IW)) ld_if();

   logic          running;
   logic          fetch_en;
   logic [IW-1:0] inst_addr;
   logic [DW-1:0] inst_out;
   logic          inst_valid;

   inst_mem_loadable #(.IW(IW), .DW(DW), .NOP_WORD('0)) dut (
      .Clk         (clk),
      .Reset_n     (rst_n),
      .ld          (ld_if.slave),
      .Running     (running),
      .InstAddress (inst_addr),
      .FetchEn     (fetch_en),
      .InstOut     (inst_out),
      .InstValid   (inst_valid)
   );

   int checks = 0;
   int errors = 0;

   logic [DW-1:0] m_mem [1024];
   int            m_loaded = 0;
   logic [DW-1:0] m_out = '0;
   logic [7:0]    byte_q[$];

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start(int len);
      ld_if.LoadStart = 1'b1;
      ld_if.LoadLen   = len[IW:0];
      tick();
      ld_if.LoadStart = 1'b0;
   endtask

   // Stream byte_q with gaps, then check the done pulse and update the model.
   task automatic send(int gmin, int gmax, int len);
      int gaps;
      for (int i = 0; i < byte_q.size(); i++) begin
         ld_if.LoadValid = 1'b1;
         ld_if.LoadData  = byte_q[i];
         chk("ready_byte", ld_if.LoadReady, 1);
         tick();
         ld_if.LoadValid = 1'b0;
         if (i != byte_q.size() - 1) begin
            chk("no_early_done", ld_if.LoadDone, 0);
            gaps = $urandom_range(gmax, gmin);
            for (int g = 0; g < gaps; g++) begin
               chk("ready_gap", ld_if.LoadReady, 1);
               tick();
            end
         end
      end
      chk("done", ld_if.LoadDone, 1);
      chk("run_after_load", running, 1);
      chk("ready_off", ld_if.LoadReady, 0);
      tick();
      chk("done_one_cycle", ld_if.LoadDone, 0);
      for (int w = 0; w < len; w++) begin
         int v;
         v = int'(byte_q[2*w]) + 256 * int'(byte_q[2*w+1]);
         m_mem[w] = v[DW-1:0];
      end
      m_loaded = len;
   endtask

   task automatic fetch(int a, string tag);
      fetch_en  = 1'b1;
      inst_addr = a[IW-1:0];
      tick();
      m_out = (a < m_loaded) ? m_mem[a] : '0;
      chk(tag, inst_out, m_out);
      chk({tag, "_valid"}, inst_valid, 1);
   endtask

   task automatic rand_bytes(int len);
      byte_q.delete();
      for (int i = 0; i < 2 * len; i++) byte_q.push_back(8'($urandom));
   endtask

   initial begin
      ld_if.LoadStart = 1'b0;
      ld_if.LoadLen   = '0;
      ld_if.LoadData  = '0;
      ld_if.LoadValid = 1'b0;
      fetch_en  = 1'b0;
      inst_addr = '0;
      tick();
      tick();
      rst_n = 1'b1;

      fetch_en = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("idle_valid", inst_valid, 0);
         chk("idle_out", inst_out, 0);
         chk("idle_running", running, 0);
         chk("idle_ready", ld_if.LoadReady, 0);
      end
      fetch_en = 1'b0;

      byte_q = '{8'hE0, 8'h00, 8'hB0, 8'h00, 8'h91, 8'h00};
      start(3);
      send(0, 0, 3);
      fetch(0, "f0");
      chk("f0_lit", inst_out, 9'h0E0);
      fetch(1, "f1");
      chk("f1_lit", inst_out, 9'h0B0);
      fetch(2, "f2");
      chk("f2_lit", inst_out, 9'h091);
      fetch(3, "f3_nop");
      fetch_en = 1'b0;
      tick();
      chk("stall_valid", inst_valid, 0);
      chk("stall_hold", inst_out, m_out);

      byte_q = '{8'h12, 8'hFF};
      start(1);
      chk("reload_running", running, 0);
      chk("reload_valid", inst_valid, 0);
      send(0, 0, 1);
      fetch(0, "rl0");
      chk("rl0_lit", inst_out, 9'h112);
      fetch(1, "rl1_nop");
      fetch_en = 1'b0;

      byte_q = '{8'hE0, 8'h00, 8'hB0, 8'h00, 8'h91, 8'h00};
      start(3);
      send(2, 2, 3);
      for (int a = 0; a < 4; a++) fetch(a, "gap_f");
      fetch_en = 1'b0;

      start(0);
      chk("err0", ld_if.LoadErr, 1);
      chk("err0_run", running, 1);
      chk("err0_ready", ld_if.LoadReady, 0);
      start(1025);
      chk("err1025", ld_if.LoadErr, 1);
      chk("err1025_run", running, 1);
      start(2);
      chk("err_clear", ld_if.LoadErr, 0);
      chk("err_clear_ready", ld_if.LoadReady, 1);
      byte_q = '{8'h05, 8'h01, 8'hAA};
      for (int i = 0; i < 3; i++) begin
         ld_if.LoadValid = 1'b1;
         ld_if.LoadData  = byte_q[i];
         tick();
      end
      ld_if.LoadValid = 1'b0;
      rst_n = 1'b0;
      #2;
      chk("rst_running", running, 0);
      chk("rst_ready", ld_if.LoadReady, 0);
      chk("rst_out", inst_out, 0);
      chk("rst_valid", inst_valid, 0);
      m_loaded = 0;
      m_out = '0;
      tick();
      rst_n = 1'b1;
      tick();

      start(0);
      chk("idle_err", ld_if.LoadErr, 1);
      chk("idle_err_ready", ld_if.LoadReady, 0);
      chk("idle_err_run", running, 0);

      byte_q = '{8'h05, 8'h01};
      start(1);
      send(0, 0, 1);
      fetch(0, "pr0");
      chk("pr0_lit", inst_out, 9'h105);
      fetch(1, "pr1_nop");

      ld_if.LoadStart = 1'b1;
      ld_if.LoadLen   = 11'd1;
      tick();
      ld_if.LoadStart = 1'b0;
      fetch_en = 1'b0;
      chk("both_valid", inst_valid, 0);
      chk("both_running", running, 0);
      chk("both_hold", inst_out, m_out);
      m_loaded = 0;
      rand_bytes(1);
      send(0, 1, 1);

      for (int r = 0; r < 6; r++) begin
         int len;
         len = $urandom_range(24, 1);
         rand_bytes(len);
         start(len);
         send(0, 3, len);
         for (int c = 0; c < 30; c++) begin
            int en;
            int a;
            en = $urandom_range(1, 0);
            a  = $urandom_range(31, 0);
            fetch_en  = en[0];
            inst_addr = a[IW-1:0];
            tick();
            if (en == 1) m_out = (a < m_loaded) ? m_mem[a] : '0;
            chk("rnd_out", inst_out, m_out);
            chk("rnd_valid", inst_valid, en);
         end
         fetch_en = 1'b0;
         start(0);
         chk("rnd_err", ld_if.LoadErr, 1);
         chk("rnd_err_run", running, 1);
         chk("rnd_err_valid", inst_valid, 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
